fetch_queue: RTL and testbench

Parametrised successor to the single-entry fetch/decode boundary of the 5-stage pipeline. It owns the PC register, issues sequential fetch addresses to instruction memory, and buffers fetched instructions in a DEPTH-entry FIFO. Decode pops the FIFO at its own rate, so a decode stall no longer freezes fetch. A branch/jump redirect from Execute restarts fetch and discards all speculative entries. It sits between the instruction memory and the decode stage, replacing the PC register and the F/D pipeline register.

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch/decode boundary bundle: instruction-memory request/response, Execute redirect and decode-side head.
// master = fetch_queue side, slave = the surrounding pipeline and instruction memory.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] PCF;
  logic            ImemReadyF;
  logic [31:0]     InstrF;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            StallD;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;
  logic [CW-1:0]   CountF;

  modport master (
    input  ImemReadyF, InstrF, PCSrcE, PCTargetE, StallD,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, CountF
  );

  modport slave (
    output ImemReadyF, InstrF, PCSrcE, PCTargetE, StallD,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, CountF
  );
endinterface

// File: rtl/fetch_queue.sv
// PC register plus DEPTH-entry fetch FIFO; fetch-to-decode latency exactly 1 cycle, no bypass.
// Backpressure: StallD holds the head; fetch stops only when full with no pop; redirect flushes everything.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.master fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            valid;
  logic            pop;
  logic            push;
  entry_t          head;

  assign pc_plus4 = pc + XLEN'(4);
  assign valid    = (count != '0);
  assign pop      = valid & ~fq.StallD;
  // A pop frees a slot in the same edge, so a full queue can still accept a fetch.
  assign push     = fq.ImemReadyF & ~fq.PCSrcE & ((count < CW'(DEPTH)) | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (fq.PCSrcE) begin
      pc     <= {fq.PCTargetE[XLEN-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc     <= pc_plus4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= '{instr: fq.InstrF, pc: pc, pc_plus4: pc_plus4};
    end
  end

  assign head        = mem[rd_ptr];
  assign fq.PCF      = pc;
  assign fq.ValidD   = valid;
  assign fq.CountF   = count;
  assign fq.InstrD   = valid ? head.instr    : NOP;
  assign fq.PCD      = valid ? head.pc       : '0;
  assign fq.PCPlus4D = valid ? head.pc_plus4 : '0;

  // Redirect targets are word-aligned, so the low target bits are dropped.
  logic unused_tgt_lo;
  assign unused_tgt_lo = &{1'b0, fq.PCTargetE[1:0]};

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= CW'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (count == CW'(DEPTH) && !pop) |-> !push);
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner sequences and random traffic vs a queue model.
module tb_fetch_queue;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0), .NOP(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (bus.master)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at the negative edge: compares DUT against the model, drives inputs, steps the model at the edge.
  task automatic step(input logic r, input logic rdy, input logic src,
                      input logic stall, input logic [31:0] tgt);
    logic pop, push;
    check("PCF", bus.PCF, m_pc);
    check("ValidD", {31'd0, bus.ValidD}, {31'd0, m_q.size() != 0});
    check("CountF", 32'(bus.CountF), 32'(m_q.size()));
    check("PCD", bus.PCD, (m_q.size() != 0) ? m_q[0] : 32'd0);
    check("PCPlus4D", bus.PCPlus4D, (m_q.size() != 0) ? m_q[0] + 32'd4 : 32'd0);
    check("InstrD", bus.InstrD, (m_q.size() != 0) ? imem(m_q[0]) : NOP);
    reset          = r;
    bus.ImemReadyF = rdy;
    bus.PCSrcE     = src;
    bus.StallD     = stall;
    bus.PCTargetE  = tgt;
    bus.InstrF     = imem(m_pc);
    @(posedge clk);
    if (r) begin
      m_pc = 32'd0;
      m_q.delete();
    end else if (src) begin
      m_pc = tgt & ~32'd3;
      m_q.delete();
    end else begin
      pop  = (m_q.size() != 0) && !stall;
      push = rdy && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  typedef struct {
    logic        rdy, src, stall;
    logic [31:0] tgt;
    logic [31:0] pcf;
    logic        vld;
    int          cnt;
    logic [31:0] pcd;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic src, input logic stall,
                              input logic [31:0] tgt, input logic [31:0] pcf,
                              input logic vld, input int cnt, input logic [31:0] pcd);
    vec_t v;
    v.rdy = rdy; v.src = src; v.stall = stall; v.tgt = tgt;
    v.pcf = pcf; v.vld = vld; v.cnt = cnt; v.pcd = pcd;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    // Expected outputs are those observed in the row's cycle, before its inputs take effect.
    tbl[0]  = mk(1, 0, 0, 0,      32'h00,  0, 0, 32'h00);
    tbl[1]  = mk(1, 0, 0, 0,      32'h04,  1, 1, 32'h00);
    tbl[2]  = mk(1, 0, 1, 0,      32'h08,  1, 1, 32'h04);
    tbl[3]  = mk(1, 0, 1, 0,      32'h0C,  1, 2, 32'h04);
    tbl[4]  = mk(1, 0, 1, 0,      32'h10,  1, 3, 32'h04);
    tbl[5]  = mk(1, 0, 1, 0,      32'h14,  1, 4, 32'h04);
    tbl[6]  = mk(1, 0, 0, 0,      32'h14,  1, 4, 32'h04);
    tbl[7]  = mk(1, 0, 0, 0,      32'h18,  1, 4, 32'h08);
    tbl[8]  = mk(0, 0, 0, 0,      32'h1C,  1, 4, 32'h0C);
    tbl[9]  = mk(0, 0, 1, 0,      32'h1C,  1, 3, 32'h10);
    tbl[10] = mk(1, 1, 0, 32'h103, 32'h1C, 1, 3, 32'h10);
    tbl[11] = mk(1, 0, 0, 0,      32'h100, 0, 0, 32'h00);
    tbl[12] = mk(0, 0, 0, 0,      32'h104, 1, 1, 32'h100);
    tbl[13] = mk(0, 0, 0, 0,      32'h104, 0, 0, 32'h00);
    tbl[14] = mk(1, 0, 0, 0,      32'h104, 0, 0, 32'h00);

    reset = 1'b1;
    bus.ImemReadyF = 1'b0;
    bus.PCSrcE = 1'b0;
    bus.StallD = 1'b0;
    bus.PCTargetE = '0;
    bus.InstrF = '0;
    m_pc = 32'd0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    step(1, 1, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check($sformatf("tbl%0d.PCF", i), bus.PCF, tbl[i].pcf);
      check($sformatf("tbl%0d.ValidD", i), {31'd0, bus.ValidD}, {31'd0, tbl[i].vld});
      check($sformatf("tbl%0d.CountF", i), 32'(bus.CountF), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d.PCD", i), bus.PCD, tbl[i].pcd);
      step(0, tbl[i].rdy, tbl[i].src, tbl[i].stall, tbl[i].tgt);
    end

    // Fill to three entries at 0x40.., then reset together with a redirect.
    @(negedge clk); step(0, 1, 1, 1, 32'h40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); step(0, 1, 0, 1, 0);
    end
    @(negedge clk);
    check("pre_reset.CountF", 32'(bus.CountF), 32'd3);
    check("pre_reset.PCF", bus.PCF, 32'h4C);
    step(1, 1, 1, 0, 32'h300);
    @(negedge clk);
    check("post_reset.PCF", bus.PCF, 32'h0);
    check("post_reset.ValidD", {31'd0, bus.ValidD}, 32'd0);
    check("post_reset.InstrD", bus.InstrD, NOP);
    step(0, 1, 0, 0, 0);
    @(negedge clk);
    check("after_reset.PCD", bus.PCD, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 4, $urandom);
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, $urandom);
        @(negedge clk);
      end
    end
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
